// File: rtl/data_mem_param_if.sv
// data_mem_param_if -- request/response bundle for data_mem_param.
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  width of addr
//
// Signals (direction as seen by the memory, modport slave):
//   wr_en         in   write request
//   rd_en         in   read request
//   addr          in   word address (upper bits aliased by the memory)
//   byte_en       in   per-byte write mask, bit i covers data[8i+7:8i]
//   data_in       in   write data
//   data_out      out  registered read data
//   rd_valid      out  one-cycle strobe, data_out valid in the same cycle
//   busy          out  clear sequence in progress, requests dropped
//   test_data_out out  combinational view of word 0
interface data_mem_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic                  busy;
  logic [DATA_W-1:0]     test_data_out;

  modport master (
    output wr_en, rd_en, addr, byte_en, data_in,
    input  data_out, rd_valid, busy, test_data_out
  );

  modport slave (
    input  wr_en, rd_en, addr, byte_en, data_in,
    output data_out, rd_valid, busy, test_data_out
  );
endinterface

// File: rtl/data_mem_param.sv
// data_mem_param -- single-port word-addressed data memory for the MIPS MEM
// stage. Per-byte write enables, registered read-first read with a valid
// strobe, combinational word-0 debug tap.
//
// Parameters:
//   DATA_W      word width (multiple of 8)
//   ADDR_W      width of bus.addr
//   DEPTH_LOG2  log2 of word count (<= ADDR_W); only addr[DEPTH_LOG2-1:0]
//               is decoded, upper bits alias.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset
//   bus   data_mem_param_if.slave (see interface header)
//
// Build option: define DATA_MEM_CLEAR_EN to include the post-reset clear
// sequencer (busy high for DEPTH cycles while every word is zeroed). Without
// it busy is tied low and array contents after reset are undefined.
module data_mem_param #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_param_if.slave    bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic [DATA_W-1:0]     r_data_out;
  logic                  r_rd_valid;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic                  w_ready;
  logic                  w_addr_unused;

  assign w_addr        = bus.addr[DEPTH_LOG2-1:0];
  assign w_addr_unused = &{1'b0, bus.addr};

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_clr_idx, w_clr_idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_ready       = 1'b0;
    case (r_state)
      CLEAR: begin
        if (r_clr_idx == '1) w_state_nxt = READY;
        else                 w_clr_idx_nxt = r_clr_idx + 1'b1;
      end
      READY: w_ready = 1'b1;
    endcase
  end

  assign bus.busy = (r_state == CLEAR);
`else
  assign w_ready  = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // The array shares the reset-sensitive process so that no array write can
  // happen while rst is low; the array itself is never reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
`ifdef DATA_MEM_CLEAR_EN
      if (r_state == CLEAR) r_mem[r_clr_idx] <= '0;
`endif
      if (w_ready && bus.wr_en) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (bus.byte_en[i]) r_mem[w_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
        end
      end
      // Non-blocking read alongside the write gives read-first behaviour.
      if (w_ready && bus.rd_en) r_data_out <= r_mem[w_addr];
      r_rd_valid <= w_ready && bus.rd_en;
    end
  end

  assign bus.data_out      = r_data_out;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.test_data_out = r_mem[0];
endmodule

// File: tb/tb_data_mem_param.sv
module tb_data_mem_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_param_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
  data_mem_param_if #(.DATA_W(32), .ADDR_W(16)) bus_b ();

  data_mem_param #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(6)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  data_mem_param #(.DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

`ifdef DATA_MEM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model for the 16x64 instance: plain word array plus held read data.
  logic [15:0] mdl [64];
  logic [15:0] mdl_dout;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] a;
    logic [1:0]  be;
    logic [15:0] d;
    logic [15:0] exp_dout;
    logic        exp_v;
    logic [15:0] exp_tdo;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic wr, input logic rd, input logic [15:0] a,
                         input logic [1:0] be, input logic [15:0] d);
    bus_a.wr_en = wr; bus_a.rd_en = rd; bus_a.addr = a;
    bus_a.byte_en = be; bus_a.data_in = d;
  endtask

  task automatic idle_b();
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.addr = '0;
    bus_b.byte_en = '0; bus_b.data_in = '0;
  endtask

  // Apply one accepted request to the model: read sees the old word, then merge lanes.
  task automatic model_update(input logic wr, input logic rd, input logic [15:0] a,
                              input logic [1:0] be, input logic [15:0] d);
    int k;
    k = int'(a) % 64;
    if (rd) mdl_dout = mdl[k];
    if (wr) begin
      for (int i = 0; i < 2; i++)
        if (be[i]) mdl[k][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic op_a(input string nm, input logic wr, input logic rd, input logic [15:0] a,
                      input logic [1:0] be, input logic [15:0] d);
    drive_a(wr, rd, a, be, d);
    step();
    model_update(wr, rd, a, be, d);
    chk({nm, "_dout"}, {16'h0, bus_a.data_out}, {16'h0, mdl_dout});
    chk({nm, "_valid"}, {31'h0, bus_a.rd_valid}, {31'h0, rd});
    chk({nm, "_tdo"}, {16'h0, bus_a.test_data_out}, {16'h0, mdl[0]});
  endtask

  task automatic count_clear(input string nm, input int n40_addr);
    int n;
    n = 0;
    do begin
      if (n == 40) drive_a(1'b1, 1'b1, 16'(n40_addr), 2'b11, 16'hDEAD);
      else         drive_a(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      step();
      n++;
      if (n == 41) chk({nm, "_rd_in_busy_valid"}, {31'h0, bus_a.rd_valid}, 32'h0);
    end while (bus_a.busy && n < 200);
    chk({nm, "_len"}, n, 64);
    drive_a(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
  endtask

  initial begin
    int n;
    drive_a(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
    idle_b();
    for (int i = 0; i < 64; i++) mdl[i] = 16'h0;
    mdl_dout = 16'h0;

    //            wr    rd    addr      be     din       dout      v     tdo
    tbl[0]  = '{1'b1, 1'b0, 16'h0005, 2'b11, 16'hBEEF, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h0005, 2'b00, 16'h0000, 16'hBEEF, 1'b1, 16'h0000};
    tbl[2]  = '{1'b0, 1'b1, 16'h0045, 2'b00, 16'h0000, 16'hBEEF, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 1'b0, 16'h0003, 2'b11, 16'h1234, 16'hBEEF, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 16'h0003, 2'b01, 16'hABCD, 16'hBEEF, 1'b0, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 16'h0003, 2'b00, 16'h0000, 16'h12CD, 1'b1, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 16'h0003, 2'b11, 16'h1234, 16'h12CD, 1'b0, 16'h0000};
    tbl[7]  = '{1'b1, 1'b0, 16'h0003, 2'b10, 16'hABCD, 16'h12CD, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 16'h0003, 2'b00, 16'h0000, 16'hAB34, 1'b1, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 16'h0007, 2'b11, 16'h1111, 16'hAB34, 1'b0, 16'h0000};
    tbl[10] = '{1'b1, 1'b1, 16'h0007, 2'b11, 16'h2222, 16'h1111, 1'b1, 16'h0000};
    tbl[11] = '{1'b0, 1'b1, 16'h0007, 2'b00, 16'h0000, 16'h2222, 1'b1, 16'h0000};
    tbl[12] = '{1'b1, 1'b0, 16'h0009, 2'b00, 16'h5555, 16'h2222, 1'b0, 16'h0000};
    tbl[13] = '{1'b0, 1'b1, 16'h0009, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0000};
    tbl[14] = '{1'b1, 1'b0, 16'h0000, 2'b11, 16'h00FF, 16'h0000, 1'b0, 16'h00FF};
    tbl[15] = '{1'b0, 1'b1, 16'h0040, 2'b00, 16'h0000, 16'h00FF, 1'b1, 16'h00FF};

    // Reset state while rst is held low.
    #12;
    chk("rst_busy", {31'h0, bus_a.busy}, {31'h0, CLR});
    chk("rst_valid", {31'h0, bus_a.rd_valid}, 32'h0);
    chk("rst_dout", {16'h0, bus_a.data_out}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    if (CLR) begin
      count_clear("clear0", 1);
      // A write to word 1 was attempted at clear cycle 41 (after word 1 was zeroed).
    end else begin
      for (int i = 0; i < 64; i++) begin
        drive_a(1'b1, 1'b0, 16'(i), 2'b11, 16'h0);
        step();
      end
    end
    for (int i = 0; i < 64; i++) op_a("init_rd", 1'b0, 1'b1, 16'(i), 2'b00, 16'h0);

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      drive_a(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].be, tbl[i].d);
      step();
      model_update(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].be, tbl[i].d);
      chk($sformatf("tbl%0d_dout", i), {16'h0, bus_a.data_out}, {16'h0, tbl[i].exp_dout});
      chk($sformatf("tbl%0d_valid", i), {31'h0, bus_a.rd_valid}, {31'h0, tbl[i].exp_v});
      chk($sformatf("tbl%0d_tdo", i), {16'h0, bus_a.test_data_out}, {16'h0, tbl[i].exp_tdo});
    end

    // Randomized traffic against the model; addresses span the full 16-bit range.
    for (int i = 0; i < 300; i++) begin
      op_a($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 16'($urandom),
           2'($urandom), 16'($urandom));
    end
    drive_a(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);

    // Write a known nonzero word and read it so data_out is nonzero before reset.
    op_a("pre_rst_wr", 1'b1, 1'b0, 16'h000A, 2'b11, 16'h9C3A);
    op_a("pre_rst_rd", 1'b0, 1'b1, 16'h000A, 2'b00, 16'h0);

    // Asynchronous reset mid-cycle.
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'h0, bus_a.busy}, {31'h0, CLR});
    chk("arst_valid", {31'h0, bus_a.rd_valid}, 32'h0);
    chk("arst_dout", {16'h0, bus_a.data_out}, 32'h0);
    mdl_dout = 16'h0;
    step();
    rst = 1'b1;

    if (CLR) begin
      // Abort the clear at cycle 20, then the full clear must restart.
      for (int c = 1; c <= 20; c++) begin
        if (c == 3) drive_a(1'b1, 1'b0, 16'd11, 2'b11, 16'hDEAD);
        else        drive_a(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
        step();
      end
      chk("mid_clear_busy", {31'h0, bus_a.busy}, 32'h1);
      rst = 1'b0;
      #1;
      chk("abort_busy", {31'h0, bus_a.busy}, 32'h1);
      step();
      rst = 1'b1;
      count_clear("clear1", 5);
      for (int i = 0; i < 64; i++) mdl[i] = 16'h0;
      op_a("busy_wr_dropped", 1'b0, 1'b1, 16'd5, 2'b00, 16'h0);
      op_a("after_clear_11", 1'b0, 1'b1, 16'd11, 2'b00, 16'h0);
      op_a("after_clear_10", 1'b0, 1'b1, 16'd10, 2'b00, 16'h0);
    end else begin
      // Requests are served from the first edge after release.
      chk("norst_busy", {31'h0, bus_a.busy}, 32'h0);
      op_a("first_edge_wr", 1'b1, 1'b0, 16'd5, 2'b11, 16'h1357);
      op_a("first_edge_rd", 1'b0, 1'b1, 16'd5, 2'b00, 16'h0);
    end
    drive_a(1'b0, 1'b0, 16'h0, 2'b00, 16'h0);

    // 32-bit, 16-word instance: word-0 tap and aliasing.
    n = 0;
    while (bus_b.busy && n < 100) begin
      step();
      n++;
    end
    chk("b_ready", {31'h0, bus_b.busy}, 32'h0);
    bus_b.wr_en = 1'b1; bus_b.addr = 16'd0; bus_b.byte_en = 4'hF; bus_b.data_in = 32'h000000FF;
    step();
    chk("b_tdo0", bus_b.test_data_out, 32'h000000FF);
    bus_b.addr = 16'd16; bus_b.byte_en = 4'b1000; bus_b.data_in = 32'hA5A5A5A5;
    step();
    chk("b_tdo_alias", bus_b.test_data_out, 32'hA50000FF);
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b1; bus_b.addr = 16'd32;
    step();
    chk("b_rd_alias", bus_b.data_out, 32'hA50000FF);
    chk("b_rd_valid", {31'h0, bus_b.rd_valid}, 32'h1);
    idle_b();
    step();
    chk("b_valid_drop", {31'h0, bus_b.rd_valid}, 32'h0);
    chk("b_dout_hold", bus_b.data_out, 32'hA50000FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
